// File: rtl/alu_reservation_station_if.sv
// Purpose: bundles the decode, completion-broadcast and ALU-issue signals of the ALU reservation station.
// Latency: wires only; no storage or delay.
// Backpressure: in_reject pushes back on decode; exec_reject pushes back on the station.
interface alu_reservation_station_if;
  logic         flash;
  logic         in_en;
  logic [102:0] in_msg;
  logic         in_reject;
  logic         cpl_en;
  logic         cpl_kind;
  logic [15:0]  cpl_dest_phys;
  logic [31:0]  cpl_data;
  logic         exec_en;
  logic [102:0] exec_msg;
  logic         exec_reject;

  // Driver side: decode, completion bus and ALU acceptance.
  modport master (
    output flash, in_en, in_msg, cpl_en, cpl_kind, cpl_dest_phys, cpl_data, exec_reject,
    input  in_reject, exec_en, exec_msg
  );

  // Station side.
  modport slave (
    input  flash, in_en, in_msg, cpl_en, cpl_kind, cpl_dest_phys, cpl_data, exec_reject,
    output in_reject, exec_en, exec_msg
  );
endinterface

// File: rtl/alu_reservation_station.sv
// Purpose: age-ordered reservation station holding ALU instructions until both operands are woken, then issuing oldest-ready first.
// Latency: an accepted instruction can issue at the earliest in the cycle after the accepting edge; wake-ups are visible one edge later.
// Backpressure: in_reject while all DEPTH entries are full (registered count only); exec_reject holds the candidate in place.
module alu_reservation_station #(
  parameter int DEPTH = 4
) (
  input logic                        clock,
  input logic                        reset_n,
  alu_reservation_station_if.slave   port
);

  typedef struct packed {
    logic        valid;
    logic [31:0] data;   // tag lives in [15:0] while valid is 0
  } source_t;

  typedef struct packed {
    logic [7:0]  commit_id;
    logic [1:0]  aux_op;
    logic [2:0]  funct3;
    logic [7:0]  dest_logic;
    logic [15:0] dest_phys;
    source_t     src1;
    source_t     src2;
  } alu_instr_t;

  localparam int CW = $clog2(DEPTH + 1);

  alu_instr_t       entry_q [DEPTH];
  logic [DEPTH-1:0] occ_q;
  logic [CW-1:0]    count_q;

  alu_instr_t       woken   [DEPTH+1];
  alu_instr_t       entry_n [DEPTH];
  alu_instr_t       in_woken;
  alu_instr_t       exec_c;
  logic [DEPTH-1:0] occ_n;
  logic [CW-1:0]    count_n;
  logic             cand_found;
  int               cand_idx;
  int               ins_pos;
  logic             wake_en;
  logic             accept;
  logic             dispatch;

  // Write-back broadcast fills a still-pending operand whose tag matches; valid operands are left alone.
  function automatic source_t wake_src(source_t s, logic hit_en, logic [15:0] tag, logic [31:0] data);
    source_t r;
    r = s;
    if (hit_en && !s.valid && (s.data[15:0] == tag)) begin
      r.valid = 1'b1;
      r.data  = data;
    end
    return r;
  endfunction

  function automatic alu_instr_t wake_instr(alu_instr_t m, logic hit_en, logic [15:0] tag, logic [31:0] data);
    alu_instr_t r;
    r      = m;
    r.src1 = wake_src(m.src1, hit_en, tag, data);
    r.src2 = wake_src(m.src2, hit_en, tag, data);
    return r;
  endfunction

  assign wake_en        = port.cpl_en & ~port.cpl_kind;
  assign port.in_reject = (count_q == CW'(DEPTH));
  assign port.exec_en   = cand_found & ~port.flash;
  assign port.exec_msg  = exec_c;
  assign accept         = port.in_en & ~port.in_reject & ~port.flash;
  assign dispatch       = port.exec_en & ~port.exec_reject;

  // Pick the oldest occupied entry whose stored operands are both valid, and mux it out.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = 0;
    exec_c     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (occ_q[i] && entry_q[i].src1.valid && entry_q[i].src2.valid) begin
        cand_found = 1'b1;
        cand_idx   = i;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i == cand_idx) begin
        exec_c = entry_q[i];
      end
    end
  end

  // Next contents: wake every entry, close the gap left by an issued entry, then append the (bypass-woken) newcomer.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = wake_instr(entry_q[i], wake_en, port.cpl_dest_phys, port.cpl_data);
    end
    woken[DEPTH] = '0;
    in_woken = wake_instr(port.in_msg, wake_en, port.cpl_dest_phys, port.cpl_data);
    ins_pos  = int'(count_q) - (dispatch ? 1 : 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (dispatch && (i >= cand_idx)) begin
        entry_n[i] = woken[i+1];
      end else begin
        entry_n[i] = woken[i];
      end
      if (accept && (i == ins_pos)) begin
        entry_n[i] = in_woken;
      end
    end
    count_n = count_q + CW'(accept) - CW'(dispatch);
    for (int i = 0; i < DEPTH; i++) begin
      occ_n[i] = (i < int'(count_n));
    end
  end

  // Occupancy and count: reset beats flush, flush beats normal update.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
      occ_q   <= '0;
    end else if (port.flash) begin
      count_q <= '0;
      occ_q   <= '0;
    end else begin
      count_q <= count_n;
      occ_q   <= occ_n;
    end
  end

  // Payloads carry no reset; they are only meaningful where the occupancy bit is set.
  always_ff @(posedge clock) begin
    entry_q <= entry_n;
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Purpose: directed self-checking bench for the ALU reservation station.
// Latency: outputs sampled 2 time units after each rising edge, once inputs return to idle.
// Backpressure: exec_reject is driven explicitly to fill the station and to hold candidates.
module tb_alu_reservation_station;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } source_t;

  typedef struct packed {
    logic [7:0]  commit_id;
    logic [1:0]  aux_op;
    logic [2:0]  funct3;
    logic [7:0]  dest_logic;
    logic [15:0] dest_phys;
    source_t     src1;
    source_t     src2;
  } alu_instr_t;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_pass;
  alu_instr_t got;

  alu_reservation_station_if bus ();

  alu_reservation_station #(.DEPTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .port    (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [102:0] mk(input logic [7:0] id, input logic v1, input logic [31:0] d1,
                                      input logic v2, input logic [31:0] d2);
    alu_instr_t m;
    m.commit_id  = id;
    m.aux_op     = 2'b01;
    m.funct3     = 3'b010;
    m.dest_logic = id + 8'd1;
    m.dest_phys  = 16'h0100 + {8'h00, id};
    m.src1.valid = v1;
    m.src1.data  = d1;
    m.src2.valid = v2;
    m.src2.data  = d2;
    return m;
  endfunction

  // One rising edge, then return per-cycle inputs to idle and let outputs settle.
  task automatic step();
    @(posedge clock);
    #1;
    bus.in_en   = 1'b0;
    bus.cpl_en  = 1'b0;
    bus.cpl_kind = 1'b0;
    bus.flash   = 1'b0;
    #1;
    got = bus.exec_msg;
  endtask

  task automatic insert(input logic [102:0] m);
    bus.in_en  = 1'b1;
    bus.in_msg = m;
    step();
  endtask

  task automatic broadcast(input logic kind, input logic [15:0] tag, input logic [31:0] data);
    bus.cpl_en        = 1'b1;
    bus.cpl_kind      = kind;
    bus.cpl_dest_phys = tag;
    bus.cpl_data      = data;
  endtask

  initial begin
    clock = 1'b0;
    reset_n = 1'b0;
    n_checks = 0;
    n_pass = 0;
    bus.flash = 1'b0;
    bus.in_en = 1'b0;
    bus.in_msg = '0;
    bus.cpl_en = 1'b0;
    bus.cpl_kind = 1'b0;
    bus.cpl_dest_phys = '0;
    bus.cpl_data = '0;
    bus.exec_reject = 1'b0;
    step();
    step();
    check("reset_exec_en", 64'(bus.exec_en), 64'd0);
    check("reset_in_reject", 64'(bus.in_reject), 64'd0);
    reset_n = 1'b1;
    step();

    // Ready instruction issues the cycle after acceptance and then drains.
    insert(mk(8'd5, 1'b1, 32'd3, 1'b1, 32'd4));
    check("ready_exec_en", 64'(bus.exec_en), 64'd1);
    check("ready_id", 64'(got.commit_id), 64'd5);
    check("ready_src1", 64'(got.src1), {31'd0, 1'b1, 32'd3});
    check("ready_dest_phys", 64'(got.dest_phys), 64'h0105);
    step();
    check("ready_drained", 64'(bus.exec_en), 64'd0);

    // Wake-up: wrong kind and wrong tag leave the operand pending, matching write-back wakes it.
    insert(mk(8'd6, 1'b0, 32'h0000_0012, 1'b1, 32'd9));
    check("wake_pending", 64'(bus.exec_en), 64'd0);
    broadcast(1'b1, 16'h0012, 32'h1111_1111);
    step();
    check("wake_kind1_ignored", 64'(bus.exec_en), 64'd0);
    broadcast(1'b0, 16'h0013, 32'h2222_2222);
    step();
    check("wake_wrong_tag", 64'(bus.exec_en), 64'd0);
    broadcast(1'b0, 16'h0012, 32'hDEAD_BEEF);
    step();
    check("wake_exec_en", 64'(bus.exec_en), 64'd1);
    check("wake_id", 64'(got.commit_id), 64'd6);
    check("wake_src1", 64'(got.src1), {31'd0, 1'b1, 32'hDEAD_BEEF});
    step();
    check("wake_drained", 64'(bus.exec_en), 64'd0);

    // Bypass into the incoming instruction; a valid operand whose low bits look like the tag is untouched.
    broadcast(1'b0, 16'h0007, 32'hCAFE_F00D);
    insert(mk(8'd7, 1'b1, 32'h0000_0007, 1'b0, 32'h0000_0007));
    check("bypass_exec_en", 64'(bus.exec_en), 64'd1);
    check("bypass_src2", 64'(got.src2), {31'd0, 1'b1, 32'hCAFE_F00D});
    check("bypass_valid_kept", 64'(got.src1), {31'd0, 1'b1, 32'h0000_0007});
    step();

    // Fill under backpressure, overflow offer ignored, then in-order drain.
    bus.exec_reject = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      insert(mk(8'(i), 1'b1, 32'(i), 1'b1, 32'(i)));
    end
    check("full_in_reject", 64'(bus.in_reject), 64'd1);
    insert(mk(8'd5, 1'b1, 32'd5, 1'b1, 32'd5));
    check("full_still_reject", 64'(bus.in_reject), 64'd1);
    check("full_head_held", 64'(got.commit_id), 64'd1);
    bus.exec_reject = 1'b0;
    step();
    check("drain_in_reject", 64'(bus.in_reject), 64'd0);
    check("drain_id2", 64'(got.commit_id), 64'd2);
    step();
    check("drain_id3", 64'(got.commit_id), 64'd3);
    step();
    check("drain_id4", 64'(got.commit_id), 64'd4);
    step();
    check("drain_empty", 64'(bus.exec_en), 64'd0);

    // Age priority with simultaneous dispatch, wake-up and accept.
    bus.exec_reject = 1'b1;
    insert(mk(8'd1, 1'b0, 32'h0000_0021, 1'b1, 32'd0));
    insert(mk(8'd2, 1'b1, 32'd2, 1'b1, 32'd2));
    insert(mk(8'd3, 1'b1, 32'd3, 1'b1, 32'd3));
    check("age_young_first", 64'(got.commit_id), 64'd2);
    bus.exec_reject = 1'b0;
    broadcast(1'b0, 16'h0021, 32'h0000_0055);
    insert(mk(8'd4, 1'b1, 32'd4, 1'b1, 32'd4));
    check("age_woken_next", 64'(got.commit_id), 64'd1);
    check("age_woken_src1", 64'(got.src1), {31'd0, 1'b1, 32'h0000_0055});
    step();
    check("age_then_id3", 64'(got.commit_id), 64'd3);
    step();
    check("age_then_id4", 64'(got.commit_id), 64'd4);
    step();
    check("age_empty", 64'(bus.exec_en), 64'd0);

    // Flush drops held entries and blocks a same-cycle accept.
    bus.exec_reject = 1'b1;
    insert(mk(8'd8, 1'b1, 32'd8, 1'b1, 32'd8));
    insert(mk(8'd9, 1'b1, 32'd9, 1'b1, 32'd9));
    insert(mk(8'd10, 1'b1, 32'd10, 1'b1, 32'd10));
    check("flash_pre_exec_en", 64'(bus.exec_en), 64'd1);
    bus.flash = 1'b1;
    bus.in_en = 1'b1;
    bus.in_msg = mk(8'd20, 1'b1, 32'd0, 1'b1, 32'd0);
    #1;
    check("flash_exec_en_low", 64'(bus.exec_en), 64'd0);
    step();
    check("flash_exec_en", 64'(bus.exec_en), 64'd0);
    check("flash_in_reject", 64'(bus.in_reject), 64'd0);
    bus.exec_reject = 1'b0;
    insert(mk(8'd11, 1'b1, 32'd11, 1'b1, 32'd11));
    check("flash_refill_id", 64'(got.commit_id), 64'd11);
    step();
    check("flash_refill_drained", 64'(bus.exec_en), 64'd0);

    // Reset mid-operation: held entries and broadcasts during reset are dropped.
    bus.exec_reject = 1'b1;
    insert(mk(8'd12, 1'b0, 32'h0000_0040, 1'b1, 32'd0));
    insert(mk(8'd13, 1'b1, 32'd13, 1'b1, 32'd13));
    insert(mk(8'd14, 1'b1, 32'd14, 1'b1, 32'd14));
    reset_n = 1'b0;
    broadcast(1'b0, 16'h0040, 32'h0000_0077);
    bus.in_en = 1'b1;
    bus.in_msg = mk(8'd21, 1'b1, 32'd0, 1'b1, 32'd0);
    step();
    check("rst_exec_en", 64'(bus.exec_en), 64'd0);
    check("rst_in_reject", 64'(bus.in_reject), 64'd0);
    broadcast(1'b0, 16'h0040, 32'h0000_0077);
    step();
    reset_n = 1'b1;
    bus.exec_reject = 1'b0;
    insert(mk(8'd15, 1'b1, 32'd15, 1'b1, 32'd15));
    check("rst_refill_id", 64'(got.commit_id), 64'd15);
    step();
    check("rst_refill_drained", 64'(bus.exec_en), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 Parameter: DEPTH, default 4, number of age-ordered entries (2..8).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 flash  input  1  pipeline flush (branch mispredict).
REQ-005 in_en  input  1  decode offers one AluInstr.
REQ-006 in_msg  input  103  AluInstr {commit_id 8, aux_op 2, funct3 3, dest_logic 8, dest_phys 16, src1 33, src2 33}; Source = {valid 1, data/tag 32}; when valid=0 tag is bits[15:0].
REQ-007 in_reject  output  1  station cannot accept in_msg this cycle.
REQ-008 cpl_en, cpl_kind, cpl_dest_phys, cpl_data  input  1/1/16/32  completion broadcast; kind=0 is write-back.
REQ-009 exec_en  output  1  issuing a fully ready AluInstr to the ALU.
REQ-010 exec_msg  output  103  issued AluInstr; src1.valid=src2.valid=1.
REQ-011 exec_reject  input  1  ALU refuses exec_msg this cycle.

Function
REQ-012 Storage: DEPTH entries, each one AluInstr plus occupancy bit; entry 0 is oldest; occupied entries contiguous from 0; count register 0..DEPTH.
REQ-013 in_reject = (count == DEPTH); combinational from registered count only, independent of same-cycle dispatch.
REQ-014 Accept when in_en & ~in_reject & ~flash; accepted entry stored at index (count - dispatched_this_cycle).
REQ-015 Dispatch candidate: lowest-index occupied entry whose src1.valid and src2.valid are both 1 in stored state.
REQ-016 exec_en = candidate exists & ~flash; exec_msg = candidate contents, combinational from registers.
REQ-017 Entry removed at edge when exec_en & ~exec_reject; younger entries shift down by one that same edge; order preserved.
REQ-018 When exec_reject=1, the candidate stays; exec_msg may change next cycle only if an older entry becomes ready.
REQ-019 Wake-up: at each edge with cpl_en & ~cpl_kind, every stored operand with valid=0 and tag==cpl_dest_phys becomes valid=1, data=cpl_data; effect visible from next cycle.
REQ-020 Accepted in_msg is woken by the same-cycle broadcast before storage (bypass); a stored-and-woken operand is never lost on shift.
REQ-021 Latency: instruction accepted at edge N is dispatchable no earlier than cycle after edge N (one cycle minimum residency).
REQ-022 Simultaneous accept, dispatch and wake-up in one cycle: all three apply; count' = count + accept - dispatch.
REQ-023 cpl_kind=1 or cpl_en=0: no operand changes.
REQ-024 flash=1: at edge, all entries invalidated, count=0; no accept, exec_en=0 that cycle.
REQ-025 Already-valid operands never overwritten by broadcasts.

Reset
REQ-026 reset_n=0 at edge: count=0, all occupancy bits 0; exec_en=0, in_reject=0 from next cycle; entry payloads don't-care.
REQ-027 Reset has priority over flash, accept and dispatch; reset mid-operation drops all held instructions.

Verification
REQ-028 Ready insert: in_msg commit_id=5 src1={1,3} src2={1,4} at N -> exec_en=1, exec_msg.commit_id=5 at N+1; count 0 at N+2 with exec_reject=0.
REQ-029 Wake-up: insert src1={0,tag 0x0012}; cpl_en=1 kind=0 dest_phys=0x0012 data=0xDEADBEEF next cycle -> following cycle exec_en=1, exec_msg.src1={1,0xDEADBEEF}.
REQ-030 Bypass: cpl matching src2 tag 0x0007 same cycle as insert -> exec_en=1 next cycle, src2.data=cpl_data.
REQ-031 Full/backpressure: exec_reject=1, insert 4 ready entries ids 1..4 -> in_reject=1; 5th in_en ignored; release exec_reject -> ids 1,2,3,4 issued in order, in_reject=0 after first issue.
REQ-032 Age priority: entries id 1 (not ready), id 2 (ready) -> id 2 issues first; wake id 1 -> id 1 issues next; ordering of remaining entries unchanged.
REQ-033 Flash/reset: 3 entries held, flash=1 one cycle -> count=0, exec_en=0, in_reject=0; repeat with reset_n=0 -> same result, cpl broadcasts during reset ignored.
